// File: rtl/snax_wide_bank_pkg.sv
// Shared types and default geometry for the wide-to-bank request splitter.
package snax_wide_bank_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StIssue   = 2'd1,
    StCapture = 2'd2,
    StResp    = 2'd3
  } state_e;

  localparam int unsigned DefNarrowDataWidth = 32;
  localparam int unsigned DefWideDataWidth   = 512;
  localparam int unsigned WideBytes          = DefWideDataWidth / 8;
  localparam int unsigned NarrowBytes        = DefNarrowDataWidth / 8;
  localparam int unsigned WideOffW           = $clog2(WideBytes);

endpackage

// File: rtl/snax_bank_issue_slot.sv
// Per-bank slot: tracks whether this bank has taken its share of the wide
// request, raises the bank valid until it has, and captures the read word
// that the bank returns one cycle after its handshake.
module snax_bank_issue_slot #(
  parameter int unsigned NarrowDataWidth = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       issue_i,
  input  logic                       load_i,
  input  logic                       preset_acc_i,
  input  logic                       read_i,
  input  logic                       q_ready_i,
  input  logic [NarrowDataWidth-1:0] p_data_i,
  output logic                       q_valid_o,
  output logic                       done_o,
  output logic [NarrowDataWidth-1:0] rbuf_o
);

  logic                       acc_q;
  logic                       pend_q;
  logic [NarrowDataWidth-1:0] rbuf_q;
  logic                       hs;

  // Valid drops permanently once accepted, so it never re-asserts for the same request.
  assign q_valid_o = issue_i & ~acc_q;
  assign hs        = q_valid_o & q_ready_i;
  assign done_o    = acc_q | hs;
  assign rbuf_o    = rbuf_q;

  // Accepted flag, pending-read flag and the read buffer.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q  <= 1'b0;
      pend_q <= 1'b0;
      rbuf_q <= '0;
    end else begin
      if (load_i)  acc_q <= preset_acc_i;
      else if (hs) acc_q <= 1'b1;
      pend_q <= hs & read_i;
      if (pend_q) rbuf_q <= p_data_i;
    end
  end

endmodule

// File: rtl/snax_wide_bank_splitter.sv
// Splits one wide memory request into one narrow request per bank and, for
// reads, reassembles the per-bank words into a single wide response.
module snax_wide_bank_splitter
  import snax_wide_bank_pkg::*;
#(
  parameter int unsigned LocalMemAddrWidth = 48,
  parameter int unsigned NarrowDataWidth   = DefNarrowDataWidth,
  parameter int unsigned WideDataWidth     = DefWideDataWidth,
  parameter int unsigned NumBanks          = WideDataWidth / NarrowDataWidth
) (
  input  logic                                      clk_i,
  input  logic                                      rst_i,
  input  logic                                      wide_q_valid_i,
  output logic                                      wide_q_ready_o,
  input  logic [LocalMemAddrWidth-1:0]              wide_q_addr_i,
  input  logic                                      wide_q_write_i,
  input  logic [WideDataWidth-1:0]                  wide_q_data_i,
  input  logic [WideDataWidth/8-1:0]                wide_q_strb_i,
  output logic                                      wide_p_valid_o,
  input  logic                                      wide_p_ready_i,
  output logic [WideDataWidth-1:0]                  wide_p_data_o,
  output logic                                      dma_access_o,
  output logic [NumBanks-1:0]                       bank_q_valid_o,
  input  logic [NumBanks-1:0]                       bank_q_ready_i,
  output logic [NumBanks*LocalMemAddrWidth-1:0]     bank_q_addr_o,
  output logic [NumBanks-1:0]                       bank_q_write_o,
  output logic [NumBanks*NarrowDataWidth-1:0]       bank_q_data_o,
  output logic [NumBanks*NarrowDataWidth/8-1:0]     bank_q_strb_o,
  input  logic [NumBanks*NarrowDataWidth-1:0]       bank_p_data_i
);

  localparam int unsigned AW  = LocalMemAddrWidth;
  localparam int unsigned NDW = NarrowDataWidth;
  localparam int unsigned NBy = NarrowDataWidth / 8;
  localparam int unsigned WBy = WideDataWidth / 8;
  // Byte-offset bits inside one wide beat; cleared to align the base.
  localparam logic [AW-1:0] OffMask = AW'(WBy - 1);

  state_e                          state_q;
  logic [AW-1:0]                   addr_q;
  logic                            write_q;
  logic [WideDataWidth-1:0]        data_q;
  logic [WBy-1:0]                  strb_q;

  logic                            in_issue;
  logic                            wide_hs;
  logic                            all_done;
  logic [NumBanks-1:0]             done;
  logic [NumBanks-1:0][NDW-1:0]    rbuf;

  // Every output is forced low while reset is held, even before the state settles.
  assign in_issue       = ~rst_i & (state_q == StIssue);
  assign wide_q_ready_o = ~rst_i & (state_q == StIdle);
  assign wide_p_valid_o = ~rst_i & (state_q == StResp);
  assign wide_p_data_o  = rst_i ? '0 : rbuf;
  assign dma_access_o   = in_issue;
  assign wide_hs        = wide_q_valid_i & wide_q_ready_o;
  // Includes same-cycle handshakes so ISSUE exits without a spare cycle.
  assign all_done       = &done;

  for (genvar g = 0; g < NumBanks; g++) begin : g_bank
    localparam logic [AW-1:0] BankOff = AW'(g * NBy);
    logic preset;

    // Write banks with no enabled byte are treated as already accepted.
    assign preset = wide_q_write_i & ~|wide_q_strb_i[g*NBy +: NBy];

    snax_bank_issue_slot #(
      .NarrowDataWidth (NDW)
    ) u_slot (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .issue_i      (in_issue),
      .load_i       (wide_hs),
      .preset_acc_i (preset),
      .read_i       (~write_q),
      .q_ready_i    (bank_q_ready_i[g]),
      .p_data_i     (bank_p_data_i[g*NDW +: NDW]),
      .q_valid_o    (bank_q_valid_o[g]),
      .done_o       (done[g]),
      .rbuf_o       (rbuf[g])
    );

    assign bank_q_addr_o[g*AW +: AW]    = rst_i ? '0 : addr_q + BankOff;
    assign bank_q_write_o[g]            = ~rst_i & write_q;
    assign bank_q_data_o[g*NDW +: NDW]  = rst_i ? '0 : data_q[g*NDW +: NDW];
    assign bank_q_strb_o[g*NBy +: NBy]  = rst_i ? '0 : strb_q[g*NBy +: NBy];
  end

  // Control FSM plus the registered copy of the accepted wide request.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      addr_q  <= '0;
      write_q <= 1'b0;
      data_q  <= '0;
      strb_q  <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (wide_q_valid_i) begin
            addr_q  <= wide_q_addr_i & ~OffMask;
            write_q <= wide_q_write_i;
            data_q  <= wide_q_data_i;
            strb_q  <= wide_q_strb_i;
            state_q <= StIssue;
          end
        end
        StIssue: begin
          if (all_done) state_q <= write_q ? StIdle : StCapture;
        end
        // Last bank words land in rbuf during this cycle.
        StCapture: state_q <= StResp;
        StResp: begin
          if (wide_p_ready_i) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
